dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Sequencing arbiter sharing one data_memory between the CPU load/store path and
// the DMA/debug loader; misaligned accesses are answered with err and never reach memory.
module dmem_arbiter #(
  parameter int MEM_LAT = 0,
  parameter bit RR      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_funct3,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  state_t        state, state_nxt;
  logic          last_dma;   // 1 when the DMA side received the most recent grant
  logic          own_dma;
  logic          bad;
  logic          is_store;
  logic [CW-1:0] wcnt;

  logic          pick_c, pick_d, take, done;
  logic          win_dma, win_we, win_bad;
  logic [31:0]   win_addr, win_wdata, win_rdata;
  logic [2:0]    win_funct3;

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b10:   return addr_lo != 2'b00;
      2'b01:   return addr_lo[0];
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pick_c     = c_req && (!d_req || !RR || last_dma);
    pick_d     = d_req && !pick_c;
    win_dma    = pick_d;
    win_we     = pick_d ? d_we     : c_we;
    win_addr   = pick_d ? d_addr   : c_addr;
    win_wdata  = pick_d ? d_wdata  : c_wdata;
    win_funct3 = pick_d ? d_funct3 : c_funct3;
    win_bad    = misaligned(win_funct3, win_addr[1:0]);
    take       = ((state == IDLE) || (state == RESP)) && (pick_c || pick_d);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = (pick_c || pick_d) ? CMD : IDLE;
      CMD:        state_nxt = (MEM_LAT > 0) ? WAIT : RESP;
      WAIT:       state_nxt = (wcnt == CW'(1)) ? RESP : WAIT;
      default:    state_nxt = IDLE;
    endcase
    done = (state_nxt == RESP);
  end

  // Stores and errored accesses return zero data.
  assign win_rdata = (bad || is_store) ? 32'd0 : mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dma   <= 1'b1;
      own_dma    <= 1'b0;
      bad        <= 1'b0;
      is_store   <= 1'b0;
      wcnt       <= '0;
      c_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      c_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      c_err      <= 1'b0;
      d_err      <= 1'b0;
      c_rdata    <= 32'd0;
      d_rdata    <= 32'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_funct3 <= 3'b010;
    end else begin
      c_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      c_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      c_err     <= 1'b0;
      d_err     <= 1'b0;
      c_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;

      if (take) begin
        own_dma    <= win_dma;
        last_dma   <= win_dma;
        bad        <= win_bad;
        is_store   <= win_we;
        wcnt       <= CW'(MEM_LAT);
        mem_addr   <= win_addr;
        mem_wdata  <= win_wdata;
        mem_funct3 <= win_funct3;
        c_gnt      <= !win_dma;
        d_gnt      <= win_dma;
        mem_read   <= !win_we && !win_bad;
        mem_write  <= win_we && !win_bad;
      end

      if (state == WAIT) wcnt <= wcnt - CW'(1);

      if (done) begin
        c_rvalid <= !own_dma;
        d_rvalid <= own_dma;
        c_err    <= !own_dma && bad;
        d_err    <= own_dma && bad;
        c_rdata  <= own_dma ? 32'd0 : win_rdata;
        d_rdata  <= own_dma ? win_rdata : 32'd0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (LAT0/RR, LAT0/fixed, LAT2/RR)
// share one stimulus; responses are matched against a scoreboard queue.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0]  c_funct3, d_funct3;
  logic        pre_we;
  logic [31:0] pre_addr, pre_data;

  logic        c_gnt[3], d_gnt[3], c_rvalid[3], d_rvalid[3], c_err[3], d_err[3];
  logic        mem_read[3], mem_write[3], busy[3];
  logic [31:0] c_rdata[3], d_rdata[3], mem_addr[3], mem_wdata[3];
  logic [2:0]  mem_funct3[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 2 : 0;
    localparam bit POL = (g == 1) ? 1'b0 : 1'b1;
    logic [31:0] mem [64];
    logic        d1, d2;
    logic [31:0] rd;

    dmem_arbiter #(.MEM_LAT(LAT), .RR(POL)) u_dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
      .c_gnt(c_gnt[g]), .c_rvalid(c_rvalid[g]), .c_rdata(c_rdata[g]), .c_err(c_err[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]), .d_err(d_err[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_funct3(mem_funct3[g]), .mem_rdata(rd), .busy(busy[g])
    );

    // Memory model: read data is only valid LAT cycles after the read command.
    always @(posedge clk) begin
      d1 <= mem_read[g];
      d2 <= d1;
      if (mem_write[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
      else if (pre_we)  mem[pre_addr[7:2]]    <= pre_data;
    end
    assign rd = (LAT == 0 || d2) ? mem[mem_addr[g][7:2]] : 32'hBAD0_BAD0;
  end

  typedef struct {
    int          inst;
    bit          dma;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  resp_t sb[$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    wr_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_seen += int'(mem_write[0]);
  endtask

  task automatic push(input int inst, input bit dma, input logic [31:0] rdata, input bit err);
    sb.push_back('{inst: inst, dma: dma, rdata: rdata, err: err});
  endtask

  task automatic expect_resp(input int inst, input int budget, input int exp_lat);
    resp_t e;
    int    k;
    bit    got;
    bit    dma;
    got = 1'b0;
    k   = 0;
    while (!got && k < budget) begin
      tick();
      k++;
      if (c_rvalid[inst] || d_rvalid[inst]) got = 1'b1;
    end
    check("resp_seen", 32'(got), 32'd1);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("resp_inst", 32'(inst), 32'(e.inst));
    if (got) begin
      dma = d_rvalid[inst];
      check("resp_lat", 32'(k), 32'(exp_lat));
      check("resp_port", 32'(dma), 32'(e.dma));
      check("resp_rdata", dma ? d_rdata[inst] : c_rdata[inst], e.rdata);
      check("resp_err", 32'(dma ? d_err[inst] : c_err[inst]), 32'(e.err));
      check("resp_single", 32'(c_rvalid[inst] && d_rvalid[inst]), 32'd0);
    end
  endtask

  task automatic check_reset(input int i);
    check("rst_ctrl", 32'({c_gnt[i], d_gnt[i], c_rvalid[i], d_rvalid[i], c_err[i], d_err[i],
                           mem_read[i], mem_write[i], busy[i]}), 32'd0);
    check("rst_c_rdata", c_rdata[i], 32'd0);
    check("rst_d_rdata", d_rdata[i], 32'd0);
    check("rst_mem_addr", mem_addr[i], 32'd0);
    check("rst_mem_wdata", mem_wdata[i], 32'd0);
    check("rst_mem_funct3", 32'(mem_funct3[i]), 32'd2);
  endtask

  initial begin
    logic [1:0] e_rr;
    int         w0;

    rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0; c_funct3 = 3'b010;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_funct3 = 3'b010;
    pre_we = 1'b0; pre_addr = 32'd0; pre_data = 32'd0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) check_reset(i);
    rst = 1'b0;

    pre_we = 1'b1; pre_addr = 32'h10; pre_data = 32'hDEAD_BEEF;
    tick();
    pre_we = 1'b0;

    // Tie with both sides held: RR alternates starting with CPU, fixed priority stays on CPU.
    c_req = 1'b1; c_addr = 32'h10;
    d_req = 1'b1; d_addr = 32'h10;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_rr = (k == 1 || k == 5) ? 2'b10 : (k == 3 || k == 7) ? 2'b01 : 2'b00;
      check("tie_rr", 32'({c_gnt[0], d_gnt[0]}), 32'(e_rr));
      check("tie_fixed", 32'({c_gnt[1], d_gnt[1]}), (k % 2 == 1) ? 32'd2 : 32'd0);
      if (k == 7) begin
        c_req = 1'b0;
        d_req = 1'b0;
      end
    end
    repeat (6) tick();

    // Single CPU word load at MEM_LAT=0.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_funct3 = 3'b010;
    push(0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    tick();
    check("ld_gnt", 32'({c_gnt[0], d_gnt[0]}), 32'd2);
    check("ld_strobes", 32'({mem_read[0], mem_write[0]}), 32'd2);
    check("ld_addr", mem_addr[0], 32'h10);
    check("ld_busy", 32'(busy[0]), 32'd1);
    c_req = 1'b0;
    expect_resp(0, 4, 1);
    repeat (4) tick();

    // DMA store, then CPU load of the same word issued from RESP.
    w0 = wr_seen;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_funct3 = 3'b010;
    push(0, 1'b1, 32'd0, 1'b0);
    tick();
    check("st_gnt", 32'({c_gnt[0], d_gnt[0]}), 32'd1);
    check("st_strobes", 32'({mem_read[0], mem_write[0]}), 32'd1);
    check("st_addr", mem_addr[0], 32'h20);
    check("st_wdata", mem_wdata[0], 32'h1234_5678);
    d_req = 1'b0; d_we = 1'b0;
    expect_resp(0, 4, 1);
    c_req = 1'b1; c_addr = 32'h20;
    push(0, 1'b0, 32'h1234_5678, 1'b0);
    tick();
    check("ld2_strobes", 32'({mem_read[0], mem_write[0]}), 32'd2);
    c_req = 1'b0;
    expect_resp(0, 4, 1);
    check("store_once", 32'(wr_seen - w0), 32'd1);
    repeat (4) tick();

    // Alignment: misaligned lw, aligned lh, misaligned lhu and sw.
    c_req = 1'b1; c_addr = 32'h22; c_funct3 = 3'b010;
    push(0, 1'b0, 32'd0, 1'b1);
    tick();
    check("mis_lw_gnt", 32'(c_gnt[0]), 32'd1);
    check("mis_lw_strobes", 32'({mem_read[0], mem_write[0]}), 32'd0);
    c_req = 1'b0;
    expect_resp(0, 4, 1);

    c_req = 1'b1; c_addr = 32'h22; c_funct3 = 3'b001;
    push(0, 1'b0, 32'h1234_5678, 1'b0);
    tick();
    check("lh_strobes", 32'({mem_read[0], mem_write[0]}), 32'd2);
    check("lh_funct3", 32'(mem_funct3[0]), 32'd1);
    c_req = 1'b0;
    expect_resp(0, 4, 1);

    c_req = 1'b1; c_addr = 32'h21; c_funct3 = 3'b101;
    push(0, 1'b0, 32'd0, 1'b1);
    tick();
    check("mis_lhu_strobes", 32'({mem_read[0], mem_write[0]}), 32'd0);
    c_req = 1'b0;
    expect_resp(0, 4, 1);

    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h21; c_funct3 = 3'b010; c_wdata = 32'hFFFF_FFFF;
    push(0, 1'b0, 32'd0, 1'b1);
    tick();
    check("mis_sw_strobes", 32'({mem_read[0], mem_write[0]}), 32'd0);
    c_req = 1'b0; c_we = 1'b0;
    expect_resp(0, 4, 1);
    repeat (4) tick();

    // MEM_LAT=2: rvalid four cycles after the request, busy from CMD through RESP.
    c_req = 1'b1; c_addr = 32'h10; c_funct3 = 3'b010;
    push(2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    tick();
    check("lat2_gnt", 32'(c_gnt[2]), 32'd1);
    check("lat2_busy1", 32'(busy[2]), 32'd1);
    c_req = 1'b0;
    tick();
    check("lat2_busy2", 32'({busy[2], c_rvalid[2]}), 32'd2);
    tick();
    check("lat2_busy3", 32'({busy[2], c_rvalid[2]}), 32'd2);
    expect_resp(2, 4, 1);
    tick();
    check("lat2_idle", 32'(busy[2]), 32'd0);
    repeat (4) tick();

    // Reset during WAIT drops the transaction; the next tie goes to the CPU.
    c_req = 1'b1; c_addr = 32'h10;
    tick();
    c_req = 1'b0;
    tick();
    check("rst_in_wait", 32'(busy[2]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset(2);
    check_reset(0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_no_rvalid", 32'({c_rvalid[2], d_rvalid[2]}), 32'd0);
    end
    c_req = 1'b1; d_req = 1'b1;
    tick();
    check("post_rst_tie_lat2", 32'({c_gnt[2], d_gnt[2]}), 32'd2);
    check("post_rst_tie_lat0", 32'({c_gnt[0], d_gnt[0]}), 32'd2);
    c_req = 1'b0; d_req = 1'b0;
    repeat (6) tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
